// File: rtl/tlm_get_mc_fifo.sv
// Multi-channel FIFO bank behind one shared TLM-style get port (GET/TRY_GET/PEEK/TRY_PEEK + cancel).
// Latency 1 cycle from accepted request to get_ack; puts backpressure via put_ready when a channel is full.
module tlm_get_mc_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CH-1:0]                    put_valid,
  input  logic [NUM_CH*DATA_W-1:0]             put_data,
  output logic [NUM_CH-1:0]                    put_ready,
  input  logic                                 get_req,
  input  logic [CH_W-1:0]                      get_ch,
  input  logic [1:0]                           get_mode,
  input  logic                                 get_cancel,
  output logic                                 get_busy,
  output logic                                 get_ack,
  output logic                                 get_ok,
  output logic [DATA_W-1:0]                    get_data,
  output logic [NUM_CH-1:0]                    can_get,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic [CH_W-1:0]   wait_ch;
  logic              wait_peek;

  logic [DATA_W-1:0] mem    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [LVL_W-1:0]  count  [NUM_CH];

  logic [NUM_CH-1:0] not_full;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  logic [CH_W-1:0]   sel_ch;
  logic              sel_peek;
  logic              sel_avail;
  logic              complete;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      not_full[c] = (count[c] != FULL);
      can_get[c]  = (count[c] != '0);
      push[c]     = put_valid[c] && not_full[c];
      level[c*LVL_W +: LVL_W] = count[c];
    end
  end

  // Reset must hold put_ready low even though the cleared count reads "not full".
  assign put_ready = rst ? '0 : not_full;

  // In WAIT the latched request owns the port; in IDLE the live request does.
  assign sel_ch    = (state == WAIT) ? wait_ch   : get_ch;
  assign sel_peek  = (state == WAIT) ? wait_peek : get_mode[1];
  assign sel_avail = (int'(sel_ch) < NUM_CH) && can_get[sel_ch];
  assign head_data = mem[sel_ch][rd_ptr[sel_ch]];

  assign complete = sel_avail && ((state == IDLE) ? get_req : !get_cancel);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c] = complete && !sel_peek && (sel_ch == CH_W'(c));
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= put_data[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        count[c] <= count[c] + LVL_W'(push[c]) - LVL_W'(pop[c]);
      end
    end
  end

  // get_ok/get_data only change alongside get_ack so they hold between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_ch   <= '0;
      wait_peek <= 1'b0;
      get_busy  <= 1'b0;
      get_ack   <= 1'b0;
      get_ok    <= 1'b0;
      get_data  <= '0;
    end else begin
      get_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (get_req) begin
            wait_ch   <= get_ch;
            wait_peek <= get_mode[1];
            if (sel_avail) begin
              get_ack  <= 1'b1;
              get_ok   <= 1'b1;
              get_data <= head_data;
            end else if (get_mode[0]) begin
              get_ack  <= 1'b1;
              get_ok   <= 1'b0;
              get_data <= '0;
            end else begin
              state    <= WAIT;
              get_busy <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (get_cancel) begin
            state    <= IDLE;
            get_busy <= 1'b0;
            get_ack  <= 1'b1;
            get_ok   <= 1'b0;
            get_data <= '0;
          end else if (sel_avail) begin
            state    <= IDLE;
            get_busy <= 1'b0;
            get_ack  <= 1'b1;
            get_ok   <= 1'b1;
            get_data <= head_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlm_get_mc_fifo.sv
// Scoreboard bench for tlm_get_mc_fifo: expected responses queued at request time, checked on get_ack.
module tb_tlm_get_mc_fifo;

  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int LW  = 4;

  localparam logic [1:0] M_GET = 2'b00, M_TRY_GET = 2'b01, M_PEEK = 2'b10, M_TRY_PEEK = 2'b11;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     put_valid;
  logic [NCH*DW-1:0]  put_data;
  logic [NCH-1:0]     put_ready;
  logic               get_req;
  logic [1:0]         get_ch;
  logic [1:0]         get_mode;
  logic               get_cancel;
  logic               get_busy;
  logic               get_ack;
  logic               get_ok;
  logic [DW-1:0]      get_data;
  logic [NCH-1:0]     can_get;
  logic [NCH*LW-1:0]  level;

  typedef struct packed {
    logic          ok;
    logic [DW-1:0] data;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;
  int    n_vec = 0;
  int    n_err = 0;

  tlm_get_mc_fifo #(.DATA_W(DW), .DEPTH(8), .NUM_CH(NCH)) dut (
    .clk(clk), .rst(rst),
    .put_valid(put_valid), .put_data(put_data), .put_ready(put_ready),
    .get_req(get_req), .get_ch(get_ch), .get_mode(get_mode), .get_cancel(get_cancel),
    .get_busy(get_busy), .get_ack(get_ack), .get_ok(get_ok), .get_data(get_data),
    .can_get(can_get), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int ch, input logic [DW-1:0] d);
    put_valid = '0;
    put_valid[ch] = 1'b1;
    put_data[ch*DW +: DW] = d;
  endtask

  task automatic req(input int ch, input logic [1:0] mode, input logic ok, input logic [DW-1:0] d);
    get_req  = 1'b1;
    get_ch   = 2'(ch);
    get_mode = mode;
    exp_q.push_back(resp_t'{ok, d});
  endtask

  function automatic logic [LW-1:0] lvl(input int ch);
    return level[ch*LW +: LW];
  endfunction

  always @(negedge clk) begin
    if (!rst && get_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 64'(get_ack), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_ok", 64'(get_ok), 64'(mon_e.ok));
        check("ack_data", 64'(get_data), 64'(mon_e.data));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_put_ready"}, 64'(put_ready), 64'd0);
    check({tag, "_can_get"},   64'(can_get),   64'd0);
    check({tag, "_level"},     64'(level),     64'd0);
    check({tag, "_busy"},      64'(get_busy),  64'd0);
    check({tag, "_ack"},       64'(get_ack),   64'd0);
    check({tag, "_ok"},        64'(get_ok),    64'd0);
    check({tag, "_data"},      64'(get_data),  64'd0);
  endtask

  initial begin
    rst = 1'b1;
    put_valid = '0; put_data = '0;
    get_req = 1'b0; get_ch = '0; get_mode = '0; get_cancel = 1'b0;
    #12;
    check_all_zero("por");
    tick();
    rst = 1'b0;
    tick();
    check("por_rel_ready", 64'(put_ready), 64'hF);

    // Reset asserted while two channels are filling.
    put_valid = 4'b1001;
    put_data[0 +: DW]  = 32'h1;
    put_data[96 +: DW] = 32'h2;
    tick(); tick(); tick();
    check("t1_level0", 64'(lvl(0)), 64'd3);
    #2 rst = 1'b1;
    #1 check_all_zero("t1_in_rst");
    tick();
    put_valid = '0;
    rst = 1'b0;
    tick();
    check("t1_rel_ready", 64'(put_ready), 64'hF);
    check("t1_rel_level", 64'(level), 64'd0);

    // GET of a just-written word.
    put(2, 32'hA5);
    tick();
    put_valid = '0;
    req(2, M_GET, 1'b1, 32'hA5);
    tick();
    get_req = 1'b0;
    check("t2_ack", 64'(get_ack), 64'd1);
    check("t2_can_get2", 64'(can_get[2]), 64'd0);

    // TRY_GET on an empty channel.
    req(1, M_TRY_GET, 1'b0, 32'h0);
    tick();
    get_req = 1'b0;
    check("t3_ack", 64'(get_ack), 64'd1);
    check("t3_busy", 64'(get_busy), 64'd0);
    check("t3_level1", 64'(lvl(1)), 64'd0);
    tick();
    check("t3_busy_after", 64'(get_busy), 64'd0);

    // Blocking GET completes two cycles after the late put.
    req(3, M_GET, 1'b1, 32'h11);
    tick();
    get_req = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      check($sformatf("t4_busy_c%0d", cyc), 64'(get_busy), 64'd1);
      check($sformatf("t4_noack_c%0d", cyc), 64'(get_ack), 64'd0);
      put_valid = (cyc == 5) ? 4'b1000 : 4'b0000;
      put_data[96 +: DW] = 32'h11;
      tick();
    end
    put_valid = '0;
    check("t4_busy_c7", 64'(get_busy), 64'd0);
    check("t4_ack_c7", 64'(get_ack), 64'd1);

    // Fill past full, peek, drain, then wrap the pointers.
    for (int i = 1; i <= 9; i++) begin
      put(0, DW'(i));
      if (i == 9) check("t5_ready_full", 64'(put_ready[0]), 64'd0);
      tick();
    end
    put_valid = '0;
    check("t5_level_full", 64'(lvl(0)), 64'd8);
    check("t5_ready_after", 64'(put_ready[0]), 64'd0);
    req(0, M_PEEK, 1'b1, 32'd1);
    tick();
    get_req = 1'b0;
    check("t5_level_peek", 64'(lvl(0)), 64'd8);
    for (int i = 1; i <= 8; i++) begin
      req(0, M_GET, 1'b1, DW'(i));
      tick();
    end
    get_req = 1'b0;
    check("t5_level_drained", 64'(lvl(0)), 64'd0);
    check("t5_can_get0", 64'(can_get[0]), 64'd0);
    for (int i = 10; i <= 13; i++) begin
      put(0, DW'(i));
      tick();
    end
    put_valid = '0;
    check("t5_level_wrap", 64'(lvl(0)), 64'd4);
    for (int i = 10; i <= 13; i++) begin
      req(0, M_GET, 1'b1, DW'(i));
      tick();
    end
    get_req = 1'b0;
    check("t5_level_end", 64'(lvl(0)), 64'd0);

    // Cancel beats a same-cycle put; next request accepted alongside the cancel ack.
    req(1, M_GET, 1'b0, 32'h0);
    tick();
    get_req = 1'b0;
    check("t6_busy_c1", 64'(get_busy), 64'd1);
    tick();
    check("t6_busy_c2", 64'(get_busy), 64'd1);
    tick();
    check("t6_busy_c3", 64'(get_busy), 64'd1);
    get_cancel = 1'b1;
    put(1, 32'h77);
    tick();
    get_cancel = 1'b0;
    put_valid = '0;
    check("t6_cancel_ack", 64'(get_ack), 64'd1);
    check("t6_busy_c4", 64'(get_busy), 64'd0);
    check("t6_level_kept", 64'(lvl(1)), 64'd1);
    req(1, M_TRY_GET, 1'b1, 32'h77);
    tick();
    get_req = 1'b0;
    check("t6_b2b_ack", 64'(get_ack), 64'd1);
    check("t6_level_end", 64'(lvl(1)), 64'd0);

    // Cancel outside WAIT has no effect on an immediate TRY_PEEK.
    get_cancel = 1'b1;
    req(3, M_TRY_PEEK, 1'b0, 32'h0);
    tick();
    get_req = 1'b0;
    get_cancel = 1'b0;
    check("t7_ack", 64'(get_ack), 64'd1);

    tick(); tick(); tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
